// File: rtl/mb8_cpa_rx.sv
// Segmented carry-propagate adder resolving Booth carry-save sum/carry vectors into a product.
// Optional self-check against a direct signed multiply when MB8_CPA_CHECK_EN is defined.
module mb8_cpa_rx #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [2*WIDTH-1:0]   sum1,
  input  logic [2*WIDTH-1:0]   carry1,
  input  logic [WIDTH-1:0]     mx2,
  input  logic [WIDTH-1:0]     my2,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic [7:0]           err_cnt
);

  localparam int PW   = 2 * WIDTH;
  localparam int NSEG = PW / SEG;
  localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   sum_q, carry_q, prod_q, prod_nx;
  logic [KW-1:0]   k_q;
  logic            cy_q;
  logic [SEG:0]    seg_sum;
  logic            accept, last_seg;

  assign accept    = in_valid && (state == IDLE);
  assign last_seg  = (state == ADD) && (k_q == KW'(NSEG - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign prod      = prod_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = ADD;
      ADD:     if (last_seg)  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // One SEG-bit slice per cycle, ripple carry held in cy_q between slices.
  always_comb begin
    seg_sum = {1'b0, sum_q[k_q*SEG +: SEG]} + {1'b0, carry_q[k_q*SEG +: SEG]}
            + {{SEG{1'b0}}, cy_q};
    prod_nx = prod_q;
    prod_nx[k_q*SEG +: SEG] = seg_sum[SEG-1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum_q   <= '0;
      carry_q <= '0;
      prod_q  <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
    end else if (accept) begin
      sum_q   <= sum1;
      carry_q <= carry1;
      k_q     <= '0;
      cy_q    <= 1'b0;
    end else if (state == ADD) begin
      prod_q  <= prod_nx;
      cy_q    <= seg_sum[SEG];
      k_q     <= k_q + 1'b1;
    end
  end

`ifdef MB8_CPA_CHECK_EN
  logic [PW-1:0] ref_q;
  logic          err_q;
  logic [7:0]    cnt_q;
  logic          mism;

  // prod_nx on the last slice is the final product, so the verdict is ready at DONE entry.
  assign mism    = (prod_nx != ref_q);
  assign err     = err_q;
  assign err_cnt = cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ref_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept)
        ref_q <= {{WIDTH{mx2[WIDTH-1]}}, mx2} * {{WIDTH{my2[WIDTH-1]}}, my2};
      if (last_seg) begin
        err_q <= mism;
        if (mism && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
      end else if ((state == DONE) && out_ready) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  logic unused_ops;
  assign unused_ops = ^{mx2, my2};
  assign err        = 1'b0;
  assign err_cnt    = 8'd0;
`endif

endmodule
